// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op encodings, ALUOp classes, forwarding selects,
// branch funct3 codes and the EX/MEM register bundle.
package pipeline_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned RegIdxW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110
  } alu_op_e;

  // ALUOp classes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // {instr[30], funct3} codes for register-register ops
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b1000;
  localparam logic [3:0] FN_AND = 4'b0111;
  localparam logic [3:0] FN_OR  = 4'b0110;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_SLL = 4'b0001;
  localparam logic [3:0] FN_SRL = 4'b0101;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               branch_taken;
    logic [XLEN-1:0]    branch_target;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    write_data;
    logic               zero;
    logic [RegIdxW-1:0] rd;
  } exmem_t;

  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] imm);
    return pc + (imm << 1);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM outputs of the execute stage.
interface ex_mem_stage_if;
  import pipeline_pkg::*;

  logic               IDEX_RegWrite;
  logic               IDEX_MemRead;
  logic               IDEX_MemToReg;
  logic               IDEX_MemWrite;
  logic               IDEX_Branch;
  logic               IDEX_ALUSrc;
  logic [1:0]         IDEX_ALUOp;
  logic [3:0]         IDEX_Funct;
  logic [XLEN-1:0]    IDEX_PC_out;
  logic [XLEN-1:0]    IDEX_ReadData1;
  logic [XLEN-1:0]    IDEX_ReadData2;
  logic [XLEN-1:0]    IDEX_ImmData;
  logic [RegIdxW-1:0] IDEX_rd;
  logic [1:0]         ForwardA;
  logic [1:0]         ForwardB;
  logic [XLEN-1:0]    WB_WriteData;

  logic               EXMEM_RegWrite;
  logic               EXMEM_MemRead;
  logic               EXMEM_MemToReg;
  logic               EXMEM_MemWrite;
  logic               EXMEM_BranchTaken;
  logic [XLEN-1:0]    EXMEM_BranchTarget;
  logic [XLEN-1:0]    EXMEM_ALUResult;
  logic [XLEN-1:0]    EXMEM_WriteData;
  logic               EXMEM_Zero;
  logic [RegIdxW-1:0] EXMEM_rd;

  modport master (
    output IDEX_RegWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_MemWrite, IDEX_Branch,
           IDEX_ALUSrc, IDEX_ALUOp, IDEX_Funct, IDEX_PC_out, IDEX_ReadData1,
           IDEX_ReadData2, IDEX_ImmData, IDEX_rd, ForwardA, ForwardB, WB_WriteData,
    input  EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg, EXMEM_MemWrite,
           EXMEM_BranchTaken, EXMEM_BranchTarget, EXMEM_ALUResult, EXMEM_WriteData,
           EXMEM_Zero, EXMEM_rd
  );

  modport slave (
    input  IDEX_RegWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_MemWrite, IDEX_Branch,
           IDEX_ALUSrc, IDEX_ALUOp, IDEX_Funct, IDEX_PC_out, IDEX_ReadData1,
           IDEX_ReadData2, IDEX_ImmData, IDEX_rd, ForwardA, ForwardB, WB_WriteData,
    output EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg, EXMEM_MemWrite,
           EXMEM_BranchTaken, EXMEM_BranchTarget, EXMEM_ALUResult, EXMEM_WriteData,
           EXMEM_Zero, EXMEM_rd
  );

endinterface

// File: rtl/alu64.sv
// 64-bit combinational ALU with zero flag; shifts use b[5:0].
module alu64
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[5:0];
      ALU_SRL: result = a >> b[5:0];
      ALU_SUB: result = a - b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: forwarding, ALU control decode, ALU, branch resolution and the
// EX/MEM register with reset > flush > stall > load priority.
module ex_mem_stage
  import pipeline_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);

  exmem_t          r_exmem;
  exmem_t          w_exmem_next;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic            w_less;
  logic            w_branch_cond;
  alu_op_e         w_alu_op;

  // FWD_MEM reads the registered result, so a stalled stage forwards the held value
  always_comb begin
    w_op_a = bus.IDEX_ReadData1;
    unique case (bus.ForwardA)
      FWD_MEM: w_op_a = r_exmem.alu_result;
      FWD_WB:  w_op_a = bus.WB_WriteData;
      default: w_op_a = bus.IDEX_ReadData1;
    endcase
  end

  always_comb begin
    w_fwd_b = bus.IDEX_ReadData2;
    unique case (bus.ForwardB)
      FWD_MEM: w_fwd_b = r_exmem.alu_result;
      FWD_WB:  w_fwd_b = bus.WB_WriteData;
      default: w_fwd_b = bus.IDEX_ReadData2;
    endcase
  end

  assign w_op_b = bus.IDEX_ALUSrc ? bus.IDEX_ImmData : w_fwd_b;

  always_comb begin
    w_alu_op = ALU_ADD;
    unique case (bus.IDEX_ALUOp)
      ALUOP_ADD: w_alu_op = ALU_ADD;
      ALUOP_SUB: w_alu_op = ALU_SUB;
      ALUOP_RTYPE, 2'b11: begin
        unique case (bus.IDEX_Funct)
          FN_ADD:  w_alu_op = ALU_ADD;
          FN_SUB:  w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_XOR:  w_alu_op = ALU_XOR;
          FN_SLL:  w_alu_op = ALU_SLL;
          FN_SRL:  w_alu_op = ALU_SRL;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      default: w_alu_op = ALU_ADD;
    endcase
  end

  alu64 u_alu (
    .a      (w_op_a),
    .b      (w_op_b),
    .op     (w_alu_op),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  assign w_less = $signed(w_op_a) < $signed(w_op_b);

  always_comb begin
    w_branch_cond = 1'b0;
    unique case (bus.IDEX_Funct[2:0])
      F3_BEQ:  w_branch_cond = w_alu_zero;
      F3_BNE:  w_branch_cond = !w_alu_zero;
      F3_BLT:  w_branch_cond = w_less;
      F3_BGE:  w_branch_cond = !w_less;
      default: w_branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_exmem_next               = '0;
    w_exmem_next.reg_write     = bus.IDEX_RegWrite;
    w_exmem_next.mem_read      = bus.IDEX_MemRead;
    w_exmem_next.mem_to_reg    = bus.IDEX_MemToReg;
    w_exmem_next.mem_write     = bus.IDEX_MemWrite;
    w_exmem_next.branch_taken  = bus.IDEX_Branch & w_branch_cond;
    w_exmem_next.branch_target = branch_target(bus.IDEX_PC_out, bus.IDEX_ImmData);
    w_exmem_next.alu_result    = w_alu_result;
    w_exmem_next.write_data    = w_fwd_b;
    w_exmem_next.zero          = w_alu_zero;
    w_exmem_next.rd            = bus.IDEX_rd;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_exmem <= '0;
    end else if (!stall) begin
      r_exmem <= w_exmem_next;
    end
  end

  assign bus.EXMEM_RegWrite     = r_exmem.reg_write;
  assign bus.EXMEM_MemRead      = r_exmem.mem_read;
  assign bus.EXMEM_MemToReg     = r_exmem.mem_to_reg;
  assign bus.EXMEM_MemWrite     = r_exmem.mem_write;
  assign bus.EXMEM_BranchTaken  = r_exmem.branch_taken;
  assign bus.EXMEM_BranchTarget = r_exmem.branch_target;
  assign bus.EXMEM_ALUResult    = r_exmem.alu_result;
  assign bus.EXMEM_WriteData    = r_exmem.write_data;
  assign bus.EXMEM_Zero         = r_exmem.zero;
  assign bus.EXMEM_rd           = r_exmem.rd;

endmodule
